// File: rtl/fifo_stream_reader_pkg.sv
// Shared sizing constants, occupancy encoding and the read-issue credit check for the stream reader.
package fifo_stream_reader_pkg;

  localparam int DEFAULT_WORD_SIZE  = 4;
  localparam int DEFAULT_COUNT_SIZE = 16;
  localparam int BUFFER_DEPTH       = 2;
  localparam int OCC_WIDTH          = $clog2(BUFFER_DEPTH + 1);

  typedef logic [OCC_WIDTH-1:0] occ_t;

  typedef enum logic [OCC_WIDTH-1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_state_e;

  // A read may issue only if the word it returns is guaranteed a buffer slot,
  // counting the slot a same-cycle pop frees.
  function automatic logic can_issue(input occ_t occupancy, input logic pending, input logic pop);
    logic [OCC_WIDTH:0] committed;
    committed = {1'b0, occupancy}
              + {{OCC_WIDTH{1'b0}}, pending}
              - {{OCC_WIDTH{1'b0}}, pop};
    return committed < (OCC_WIDTH + 1)'(BUFFER_DEPTH);
  endfunction

endpackage

// File: rtl/skid_buffer.sv
// Two-entry in-order output buffer; head is registered and drives the stream directly.
// Push and pop may coincide in any non-empty state without changing occupancy.
module skid_buffer
  import fifo_stream_reader_pkg::*;
#(
  parameter int WORD_SIZE = DEFAULT_WORD_SIZE
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 push,
  input  logic [WORD_SIZE-1:0] push_data,
  input  logic                 pop,
  output logic [WORD_SIZE-1:0] head_data,
  output occ_t                 occupancy
);

  occ_state_e           occ;
  logic [WORD_SIZE-1:0] head;
  logic [WORD_SIZE-1:0] tail;
  logic                 do_pop;

  assign do_pop    = pop && (occ != OCC_EMPTY);
  assign head_data = head;
  assign occupancy = occ;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      occ  <= OCC_EMPTY;
      head <= '0;
      tail <= '0;
    end else begin
      unique case ({push, do_pop})
        2'b10: begin
          if (occ == OCC_EMPTY) begin
            head <= push_data;
            occ  <= OCC_ONE;
          end else begin
            tail <= push_data;
            occ  <= OCC_FULL;
          end
        end
        2'b01: begin
          if (occ == OCC_FULL) begin
            head <= tail;
            occ  <= OCC_ONE;
          end else begin
            occ  <= OCC_EMPTY;
          end
        end
        2'b11: begin
          // Occupancy holds: the departing head is replaced from tail or directly from the new word.
          if (occ == OCC_ONE) begin
            head <= push_data;
          end else begin
            head <= tail;
            tail <= push_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a registered-output FIFO into a valid/ready stream; read-to-valid latency 2 clocks.
// Reads are issued only when a buffer slot is guaranteed, so m_ready backpressure never loses words.
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int WORD_SIZE  = DEFAULT_WORD_SIZE,
  parameter int COUNT_SIZE = DEFAULT_COUNT_SIZE
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [WORD_SIZE-1:0]  fifo_data,
  output logic                  fifo_read_enable,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [WORD_SIZE-1:0]  m_data,
  output logic                  busy,
  output logic [COUNT_SIZE-1:0] word_count
);

  occ_t occupancy;
  logic pending;
  logic pop;

  assign m_valid = (occupancy != '0);
  assign pop     = m_valid && m_ready;
  assign busy    = m_valid || pending;

  // Gating with reset keeps the first read after the first post-reset edge.
  assign fifo_read_enable = !reset && enable && !fifo_empty
                         && can_issue(occupancy, pending, pop);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending    <= 1'b0;
      word_count <= '0;
    end else begin
      pending <= fifo_read_enable;
      if (pop) begin
        word_count <= word_count + COUNT_SIZE'(1);
      end
    end
  end

  skid_buffer #(
    .WORD_SIZE(WORD_SIZE)
  ) u_skid_buffer (
    .clock    (clock),
    .reset    (reset),
    .push     (pending),
    .push_data(fifo_data),
    .pop      (pop),
    .head_data(m_data),
    .occupancy(occupancy)
  );

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboarded bench: stimulus queues expected words, a negedge monitor checks every accepted word.
module tb_fifo_stream_reader;

  localparam int W = 4;
  localparam int C = 4;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         enable = 1'b0;
  logic         m_ready = 1'b0;
  logic         fifo_empty;
  logic [W-1:0] fifo_data = '0;
  logic         fifo_read_enable;
  logic         m_valid;
  logic [W-1:0] m_data;
  logic         busy;
  logic [C-1:0] word_count;

  logic [W-1:0] mem [0:255];
  logic [7:0]   rd_ptr = '0;
  logic [7:0]   wr_ptr = '0;
  int           rd_count = 0;

  logic [W-1:0] exp_q [$];
  int           tests = 0;
  int           failed = 0;

  fifo_stream_reader #(
    .WORD_SIZE (W),
    .COUNT_SIZE(C)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .enable          (enable),
    .fifo_empty      (fifo_empty),
    .fifo_data       (fifo_data),
    .fifo_read_enable(fifo_read_enable),
    .m_valid         (m_valid),
    .m_ready         (m_ready),
    .m_data          (m_data),
    .busy            (busy),
    .word_count      (word_count)
  );

  always #5 clock = ~clock;

  // Upstream FIFO model with registered read data.
  assign fifo_empty = (rd_ptr == wr_ptr);
  always @(posedge clock) begin
    if (fifo_read_enable) begin
      fifo_data <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 8'd1;
      rd_count  <= rd_count + 1;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL unexpected_word: got %0h, nothing expected", m_data);
      end else begin
        check("stream_order", int'(m_data), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic load(input logic [W-1:0] w, input bit expected_out);
    mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 8'd1;
    if (expected_out) exp_q.push_back(w);
  endtask

  initial begin
    int vcnt;
    int r0;
    bit hold;

    reset_dut();
    check("reset_m_valid", int'(m_valid), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_word_count", int'(word_count), 0);
    check("reset_m_data", int'(m_data), 0);

    // Single word: read in cycle 0, valid in cycle 2, counted in cycle 3.
    enable = 1'b1;
    m_ready = 1'b1;
    load(4'hA, 1'b1);
    #1;
    check("single_read_cycle0", int'(fifo_read_enable), 1);
    tick();
    check("single_not_valid_cycle1", int'(m_valid), 0);
    tick();
    check("single_valid_cycle2", int'(m_valid), 1);
    check("single_data_cycle2", int'(m_data), 'hA);
    tick();
    check("single_count_cycle3", int'(word_count), 1);
    check("single_idle_cycle3", int'(busy), 0);

    // Streaming 1..8 at full rate.
    reset_dut();
    for (int i = 1; i <= 8; i++) load(4'(i), 1'b1);
    repeat (2) tick();
    vcnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (m_valid) vcnt++;
      tick();
    end
    check("stream_valid_cycles", vcnt, 8);
    check("stream_word_count", int'(word_count), 8);
    check("stream_busy_after", int'(busy), 0);
    check("stream_valid_after", int'(m_valid), 0);

    // Reset with one word buffered and one read in flight.
    m_ready = 1'b0;
    load(4'h9, 1'b0);
    load(4'hB, 1'b0);
    repeat (2) tick();
    check("pre_reset_busy", int'(busy), 1);
    check("pre_reset_valid", int'(m_valid), 1);
    reset = 1'b1;
    #1;
    check("midreset_m_valid", int'(m_valid), 0);
    check("midreset_busy", int'(busy), 0);
    check("midreset_word_count", int'(word_count), 0);
    check("midreset_m_data", int'(m_data), 0);
    check("midreset_read_enable", int'(fifo_read_enable), 0);
    tick();
    reset = 1'b0;
    m_ready = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (m_valid || busy) vcnt++;
      tick();
    end
    check("inflight_word_dropped", vcnt, 0);

    // Backpressure: 10 stalled cycles, then 3,4,5 back to back.
    reset_dut();
    m_ready = 1'b0;
    r0 = rd_count;
    load(4'h3, 1'b1);
    load(4'h4, 1'b1);
    load(4'h5, 1'b1);
    repeat (2) tick();
    hold = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (!(m_valid && m_data == 4'h3)) hold = 1'b0;
      tick();
    end
    check("stall_reads", rd_count - r0, 2);
    check("stall_hold_head", int'(hold), 1);
    m_ready = 1'b1;
    #1;
    check("drain_data_0", int'(m_data), 'h3);
    tick();
    check("drain_valid_1", int'(m_valid), 1);
    check("drain_data_1", int'(m_data), 'h4);
    tick();
    check("drain_valid_2", int'(m_valid), 1);
    check("drain_data_2", int'(m_data), 'h5);
    tick();
    check("drain_done", int'(m_valid), 0);

    // Enable drop one cycle after a read issues; 0x7 stays in the FIFO.
    reset_dut();
    enable = 1'b1;
    load(4'h6, 1'b1);
    load(4'h7, 1'b0);
    #1;
    check("endrop_read_cycle0", int'(fifo_read_enable), 1);
    tick();
    enable = 1'b0;
    r0 = rd_count;
    tick();
    check("endrop_valid", int'(m_valid), 1);
    check("endrop_data", int'(m_data), 'h6);
    repeat (4) tick();
    check("endrop_no_reads", rd_count - r0, 0);

    // Counter wrap: leftover 0x7 plus 16 new words is 17 transfers.
    reset_dut();
    exp_q.push_back(4'h7);
    for (int i = 0; i < 16; i++) load(4'(i), 1'b1);
    enable = 1'b1;
    m_ready = 1'b1;
    repeat (24) tick();
    check("wrap_word_count", int'(word_count), 1);
    check("wrap_busy", int'(busy), 0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
